// File: rtl/maze_bitmap_avl.sv
// Maze wall bitmap: Avalon-MM word store, 2-stage pixel lookup, per-frame neighbour scan.
// Define MAZE_READBACK_EN to enable the Avalon read path; otherwise AVL_READDATA is 0.
module maze_bitmap_avl #(
  parameter int CELL_SHIFT = 2,
  parameter int COLS       = 160,
  parameter int ROWS       = 120,
  parameter int NUM_OBJ    = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    AVL_CS,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic [3:0]              AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]       AVL_ADDR,
  input  logic [31:0]             AVL_WRITEDATA,
  output logic [31:0]             AVL_READDATA,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    pix_wall,
  input  logic                    frame_start,
  input  logic [NUM_OBJ*10-1:0]   obj_x,
  input  logic [NUM_OBJ*10-1:0]   obj_y,
  output logic [NUM_OBJ-1:0]      obj_wall_up,
  output logic [NUM_OBJ-1:0]      obj_wall_down,
  output logic [NUM_OBJ-1:0]      obj_wall_left,
  output logic [NUM_OBJ-1:0]      obj_wall_right,
  output logic                    scan_busy,
  output logic                    scan_done
);

  localparam int WORDS  = COLS * ROWS / 32;
  localparam int WA_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NPROBE = 4 * NUM_OBJ;
  localparam int KW     = $clog2(NPROBE);
  localparam int OW     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  logic [31:0] mem [WORDS];

  // ---------------- Avalon slave ----------------
  logic            avl_hit;
  logic [WA_W-1:0] avl_word;

  assign avl_hit  = AVL_CS && (int'(AVL_ADDR) < WORDS);
  assign avl_word = avl_hit ? AVL_ADDR[WA_W-1:0] : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (avl_hit && AVL_WRITE) begin
      for (int b = 0; b < 4; b++)
        if (AVL_BYTE_EN[b]) mem[avl_word][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
    end
  end

`ifdef MAZE_READBACK_EN
  // Registered read sees the pre-write word when read and write collide.
  always_ff @(posedge CLK) begin
    if (RESET)                     AVL_READDATA <= '0;
    else if (AVL_CS && AVL_READ)   AVL_READDATA <= avl_hit ? mem[avl_word] : '0;
  end
`else
  logic unused_rd;
  assign unused_rd    = AVL_READ;
  assign AVL_READDATA = 32'h0;
`endif

  // ---------------- pixel lookup ----------------
  int              px_cx, px_cy, px_c;
  logic            px_on;
  logic [WA_W-1:0] px_word, s1_word;
  logic [4:0]      px_bit, s1_bit;
  logic            s1_on;

  always_comb begin
    px_cx   = int'(DrawX) >> CELL_SHIFT;
    px_cy   = int'(DrawY) >> CELL_SHIFT;
    px_on   = (px_cx < COLS) && (px_cy < ROWS);
    px_c    = px_cy * COLS + px_cx;
    px_word = px_on ? WA_W'(px_c >> 5) : '0;
    px_bit  = 5'(31 - (px_c & 31));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_word  <= '0;
      s1_bit   <= '0;
      s1_on    <= 1'b0;
      pix_wall <= 1'b0;
    end else begin
      s1_word  <= px_word;
      s1_bit   <= px_bit;
      s1_on    <= px_on;
      pix_wall <= s1_on & mem[s1_word][s1_bit];
    end
  end

  // ---------------- neighbour scan ----------------
  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_PROBE, S_COMMIT} scan_state_t;

  scan_state_t                state, state_nx;
  logic [KW-1:0]              k;
  logic [NUM_OBJ-1:0][9:0]    snap_x, snap_y;
  logic [NUM_OBJ-1:0]         sh_up, sh_dn, sh_lf, sh_rt;
  logic [NUM_OBJ-1:0]         cm_up, cm_dn, cm_lf, cm_rt;

  logic [OW-1:0]   pobj;
  logic [1:0]      pdir;
  int              ocx, ocy, ncx, ncy, nc;
  logic            p_off, probe_wall;
  logic [WA_W-1:0] p_word;
  logic [4:0]      p_bit;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (frame_start) state_nx = S_LATCH;
      S_LATCH:  state_nx = S_PROBE;
      S_PROBE:  if (k == KW'(NPROBE - 1)) state_nx = S_COMMIT;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Single dedicated lookup port; an off-grid object or neighbour reads as wall.
  always_comb begin
    pobj = OW'(k >> 2);
    pdir = k[1:0];
    ocx  = int'(snap_x[pobj]) >> CELL_SHIFT;
    ocy  = int'(snap_y[pobj]) >> CELL_SHIFT;
    ncx  = ocx;
    ncy  = ocy;
    case (pdir)
      2'd0:    ncy = ocy - 1;
      2'd1:    ncy = ocy + 1;
      2'd2:    ncx = ocx - 1;
      default: ncx = ocx + 1;
    endcase
    p_off = (ocx >= COLS) || (ocy >= ROWS) ||
            (ncx < 0) || (ncx >= COLS) || (ncy < 0) || (ncy >= ROWS);
    nc         = ncy * COLS + ncx;
    p_word     = p_off ? '0 : WA_W'(nc >> 5);
    p_bit      = 5'(31 - (nc & 31));
    probe_wall = p_off | mem[p_word][p_bit];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      k      <= '0;
      snap_x <= '0;
      snap_y <= '0;
      sh_up  <= '0; sh_dn <= '0; sh_lf <= '0; sh_rt <= '0;
      cm_up  <= '0; cm_dn <= '0; cm_lf <= '0; cm_rt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_LATCH: begin
          snap_x <= obj_x;
          snap_y <= obj_y;
          k      <= '0;
        end
        S_PROBE: begin
          case (pdir)
            2'd0:    sh_up[pobj] <= probe_wall;
            2'd1:    sh_dn[pobj] <= probe_wall;
            2'd2:    sh_lf[pobj] <= probe_wall;
            default: sh_rt[pobj] <= probe_wall;
          endcase
          k <= k + 1'b1;
        end
        S_COMMIT: begin
          cm_up <= sh_up; cm_dn <= sh_dn; cm_lf <= sh_lf; cm_rt <= sh_rt;
        end
        default: ;
      endcase
    end
  end

  // New flags show on the COMMIT cycle itself, alongside scan_done.
  assign obj_wall_up    = (state == S_COMMIT) ? sh_up : cm_up;
  assign obj_wall_down  = (state == S_COMMIT) ? sh_dn : cm_dn;
  assign obj_wall_left  = (state == S_COMMIT) ? sh_lf : cm_lf;
  assign obj_wall_right = (state == S_COMMIT) ? sh_rt : cm_rt;
  assign scan_busy      = (state != S_IDLE);
  assign scan_done      = (state == S_COMMIT);

endmodule

// File: tb/tb_maze_bitmap_avl.sv
// Directed bench for maze_bitmap_avl: Avalon store, pixel pipeline, neighbour scan.
module tb_maze_bitmap_avl;

`ifdef MAZE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        CLK, RESET, AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]  AVL_BYTE_EN;
  logic [9:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic [9:0]  DrawX, DrawY;
  logic        pix_wall, frame_start;
  logic [39:0] obj_x, obj_y;
  logic [3:0]  obj_wall_up, obj_wall_down, obj_wall_left, obj_wall_right;
  logic        scan_busy, scan_done;

  int n_vec, n_err;

  maze_bitmap_avl dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .DrawX(DrawX), .DrawY(DrawY), .pix_wall(pix_wall),
    .frame_start(frame_start), .obj_x(obj_x), .obj_y(obj_y),
    .obj_wall_up(obj_wall_up), .obj_wall_down(obj_wall_down),
    .obj_wall_left(obj_wall_left), .obj_wall_right(obj_wall_right),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset(input int cycles);
    @(negedge CLK); RESET = 1'b1;
    repeat (cycles) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic avl_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_BYTE_EN = be; AVL_WRITEDATA = d;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_read(input logic [9:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  // Park on an off-grid pixel, then present (x,y); p1/p2 are pix_wall 1 and 2 cycles later.
  task automatic pixel_probe(input logic [9:0] x, input logic [9:0] y, output logic p1, output logic p2);
    @(negedge CLK); DrawX = 10'd1000; DrawY = 10'd1000;
    @(negedge CLK);
    @(negedge CLK); DrawX = x; DrawY = y;
    @(negedge CLK); p1 = pix_wall;
    @(negedge CLK); p2 = pix_wall;
  endtask

  task automatic run_scan(input int refire_at, input int wr_at, input logic [9:0] wa, input logic [31:0] wd,
                          output int done_at, output int n_done, output int n_busy, output logic [3:0] pre_up,
                          output logic [3:0] u, output logic [3:0] d, output logic [3:0] l, output logic [3:0] r);
    done_at = 0; n_done = 0; n_busy = 0; pre_up = 'x; u = 'x; d = 'x; l = 'x; r = 'x;
    @(negedge CLK); frame_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (scan_busy) n_busy++;
      if (c == 17) pre_up = obj_wall_up;
      if (scan_done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = c; u = obj_wall_up; d = obj_wall_down; l = obj_wall_left; r = obj_wall_right;
        end
      end
      frame_start   = (c == refire_at);
      AVL_CS        = (c == wr_at);
      AVL_WRITE     = (c == wr_at);
      AVL_ADDR      = wa;
      AVL_BYTE_EN   = 4'hF;
      AVL_WRITEDATA = wd;
    end
    frame_start = 1'b0; AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic p1, p2;
    do_reset(2);
    n_vec++;
    if ({AVL_READDATA, pix_wall, obj_wall_up, obj_wall_down, obj_wall_left, obj_wall_right, scan_busy, scan_done} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got rd=%h pix=%b u=%b d=%b l=%b r=%b busy=%b done=%b expected all zero",
                        AVL_READDATA, pix_wall, obj_wall_up, obj_wall_down, obj_wall_left, obj_wall_right, scan_busy, scan_done);
    end
    avl_read(10'd0, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_rd0: got %h expected 0", d); end
    avl_read(10'd599, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_rd599: got %h expected 0", d); end
    pixel_probe(10'd636, 10'd476, p1, p2);
    n_vec++; if (p2 !== 1'b0) begin n_err++; $display("FAIL reset_pix_last: got %b expected 0", p2); end
    // Array contents must be cleared by reset.
    avl_write(10'd0, 4'hF, 32'hFFFF_FFFF);
    pixel_probe(10'd0, 10'd0, p1, p2);
    n_vec++; if (p2 !== 1'b1) begin n_err++; $display("FAIL prereset_pix00: got %b expected 1", p2); end
    do_reset(1);
    pixel_probe(10'd0, 10'd0, p1, p2);
    n_vec++; if (p2 !== 1'b0) begin n_err++; $display("FAIL postreset_pix00: got %b expected 0", p2); end
  endtask

  task automatic test_write_read;
    logic [31:0] d;
    logic p1, p2;
    avl_write(10'd5, 4'b1001, 32'h8000_0001);
    avl_read(10'd5, d);
    n_vec++; if (d !== (RB ? 32'h8000_0001 : 32'h0)) begin n_err++; $display("FAIL rd_addr5: got %h expected %h", d, RB ? 32'h8000_0001 : 32'h0); end
    pixel_probe(10'd0, 10'd4, p1, p2);
    n_vec++; if (p1 !== 1'b0) begin n_err++; $display("FAIL pix_latency1: got %b expected 0", p1); end
    n_vec++; if (p2 !== 1'b1) begin n_err++; $display("FAIL pix_cell160: got %b expected 1", p2); end
    pixel_probe(10'd124, 10'd4, p1, p2);
    n_vec++; if (p2 !== 1'b1) begin n_err++; $display("FAIL pix_cell191: got %b expected 1", p2); end
    pixel_probe(10'd4, 10'd4, p1, p2);
    n_vec++; if (p2 !== 1'b0) begin n_err++; $display("FAIL pix_cell161: got %b expected 0", p2); end
    // Same-cycle read and write: read returns the old word.
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 10'd5;
    AVL_BYTE_EN = 4'hF; AVL_WRITEDATA = 32'hC000_0001;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    d = AVL_READDATA;
    n_vec++; if (d !== (RB ? 32'h8000_0001 : 32'h0)) begin n_err++; $display("FAIL rw_old_data: got %h expected %h", d, RB ? 32'h8000_0001 : 32'h0); end
    pixel_probe(10'd4, 10'd4, p1, p2);
    n_vec++; if (p2 !== 1'b1) begin n_err++; $display("FAIL rw_new_data_pix: got %b expected 1", p2); end
  endtask

  task automatic test_byte_en;
    logic [31:0] d;
    logic p1, p2;
    avl_write(10'd10, 4'b0010, 32'hFFFF_FFFF);
    avl_read(10'd10, d);
    n_vec++; if (d !== (RB ? 32'h0000_FF00 : 32'h0)) begin n_err++; $display("FAIL be_read: got %h expected %h", d, RB ? 32'h0000_FF00 : 32'h0); end
    pixel_probe(10'd60, 10'd8, p1, p2);
    n_vec++; if (p2 !== 1'b0) begin n_err++; $display("FAIL be_cx15: got %b expected 0", p2); end
    pixel_probe(10'd64, 10'd8, p1, p2);
    n_vec++; if (p2 !== 1'b1) begin n_err++; $display("FAIL be_cx16: got %b expected 1", p2); end
    pixel_probe(10'd96, 10'd8, p1, p2);
    n_vec++; if (p2 !== 1'b0) begin n_err++; $display("FAIL be_cx24: got %b expected 0", p2); end
    avl_write(10'd700, 4'hF, 32'hFFFF_FFFF);
    avl_read(10'd700, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rd_addr700: got %h expected 0", d); end
    avl_read(10'd10, d);
    n_vec++; if (d !== (RB ? 32'h0000_FF00 : 32'h0)) begin n_err++; $display("FAIL be_after700: got %h expected %h", d, RB ? 32'h0000_FF00 : 32'h0); end
    avl_write(10'd599, 4'hF, 32'h0000_0001);
    avl_read(10'd599, d);
    n_vec++; if (d !== (RB ? 32'h0000_0001 : 32'h0)) begin n_err++; $display("FAIL rd_addr599: got %h expected %h", d, RB ? 32'h1 : 32'h0); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] xs [12] = '{10'd0, 10'd4, 10'd8, 10'd124, 10'd120, 10'd64, 10'd60, 10'd92, 10'd96, 10'd636, 10'd640, 10'd636};
    logic [9:0] ys [12] = '{10'd4, 10'd4, 10'd4, 10'd4,   10'd4,   10'd8,  10'd8,  10'd8,  10'd8,  10'd476, 10'd476, 10'd480};
    logic       ex [12] = '{1'b1,  1'b1,  1'b0,  1'b1,    1'b0,    1'b1,   1'b0,   1'b1,   1'b0,   1'b1,    1'b0,    1'b0};
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (i >= 2) begin
        n_vec++;
        if (pix_wall !== ex[i-2]) begin
          n_err++; $display("FAIL b2b_pix%0d (x=%0d y=%0d): got %b expected %b", i-2, xs[i-2], ys[i-2], pix_wall, ex[i-2]);
        end
      end
      if (i < 12) begin DrawX = xs[i]; DrawY = ys[i]; end
    end
  endtask

  task automatic test_scan_corner;
    int da, nd, nb;
    logic [3:0] pu, u, d, l, r;
    do_reset(1);
    obj_x = {10'd636, 10'd640, 10'd200, 10'd0};
    obj_y = {10'd476, 10'd0,   10'd200, 10'd0};
    run_scan(0, 0, 10'd0, 32'h0, da, nd, nb, pu, u, d, l, r);
    n_vec++; if (da !== 18) begin n_err++; $display("FAIL scan1_done_cycle: got %0d expected 18", da); end
    n_vec++; if (nd !== 1)  begin n_err++; $display("FAIL scan1_done_count: got %0d expected 1", nd); end
    n_vec++; if (nb !== 18) begin n_err++; $display("FAIL scan1_busy_cycles: got %0d expected 18", nb); end
    n_vec++; if (pu !== 4'b0000) begin n_err++; $display("FAIL scan1_no_early_update: got %b expected 0000", pu); end
    n_vec++; if ({u, d, l, r} !== {4'b0101, 4'b1100, 4'b0101, 4'b1100}) begin
      n_err++; $display("FAIL scan1_flags: got u=%b d=%b l=%b r=%b expected u=0101 d=1100 l=0101 r=1100", u, d, l, r);
    end
  endtask

  task automatic test_scan_right;
    int da, nd, nb;
    logic [3:0] pu, u, d, l, r;
    avl_write(10'd50, 4'hF, 32'h0010_0000);
    obj_x[19:10] = 10'd40;
    obj_y[19:10] = 10'd40;
    run_scan(5, 0, 10'd0, 32'h0, da, nd, nb, pu, u, d, l, r);
    n_vec++; if (nd !== 1)  begin n_err++; $display("FAIL scan2_refire_count: got %0d expected 1", nd); end
    n_vec++; if (da !== 18) begin n_err++; $display("FAIL scan2_done_cycle: got %0d expected 18", da); end
    n_vec++; if (pu !== 4'b0101) begin n_err++; $display("FAIL scan2_pre_commit: got %b expected 0101", pu); end
    n_vec++; if ({u, d, l, r} !== {4'b0101, 4'b1100, 4'b0101, 4'b1110}) begin
      n_err++; $display("FAIL scan2_flags: got u=%b d=%b l=%b r=%b expected u=0101 d=1100 l=0101 r=1110", u, d, l, r);
    end
    n_vec++; if (obj_wall_right !== 4'b1110) begin n_err++; $display("FAIL scan2_hold: got %b expected 1110", obj_wall_right); end
  endtask

  task automatic test_probe_write;
    int da, nd, nb;
    logic [3:0] pu, u, d, l, r;
    // Wall at (10,9) lands in PROBE before object 1 is probed.
    run_scan(0, 2, 10'd45, 32'h0020_0000, da, nd, nb, pu, u, d, l, r);
    n_vec++; if (pu !== 4'b0101) begin n_err++; $display("FAIL scan3_pre_commit: got %b expected 0101", pu); end
    n_vec++; if ({u, r} !== {4'b0111, 4'b1110}) begin
      n_err++; $display("FAIL scan3_flags: got u=%b r=%b expected u=0111 r=1110", u, r);
    end
  endtask

  task automatic test_reset_mid_scan;
    int nd;
    nd = 0;
    @(negedge CLK); frame_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      frame_start = 1'b0;
      if (scan_done) nd++;
      if (c == 6) begin
        RESET = 1'b0;
        n_vec++;
        if ({scan_busy, scan_done, obj_wall_up, obj_wall_down, obj_wall_left, obj_wall_right} !== '0) begin
          n_err++; $display("FAIL midreset_state: got busy=%b done=%b u=%b d=%b l=%b r=%b expected all zero",
                            scan_busy, scan_done, obj_wall_up, obj_wall_down, obj_wall_left, obj_wall_right);
        end
      end
      if (c == 5) RESET = 1'b1;
    end
    n_vec++; if (nd !== 0) begin n_err++; $display("FAIL midreset_done: got %0d expected 0", nd); end
    n_vec++; if (obj_wall_up !== 4'b0000) begin n_err++; $display("FAIL midreset_flags_hold: got %b expected 0000", obj_wall_up); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    RESET = 1'b0; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_BYTE_EN = 4'h0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
    DrawX = 10'd1000; DrawY = 10'd1000; frame_start = 1'b0;
    obj_x = '0; obj_y = '0;
    test_reset;
    test_write_read;
    test_byte_en;
    test_back_to_back;
    test_scan_corner;
    test_scan_right;
    test_probe_write;
    test_reset_mid_scan;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maze_bitmap_avl.md
# maze_bitmap_avl

Parametrised maze store for the tank game. It holds the wall bitmap as an Avalon-MM writable word array and returns the wall bit for each VGA pixel through a fixed-latency pipeline. Once per frame it runs a sequenced neighbour-wall scan for up to NUM_OBJ tanks and bullets. It replaces the inline Maze_Reg lookup in the VGA/Avalon top level and feeds color_mapper and the collision logic.

## Interface
- CELL_SHIFT, 2: pixels per cell = 2^CELL_SHIFT.
- COLS, 160: cells per row.
- ROWS, 120: cell rows.
- NUM_OBJ, 4: object scan channels, 1..8.
- WORDS, derived = COLS*ROWS/32 (600 at defaults); COLS*ROWS must be a multiple of 32.
- ADDR_W, 10: Avalon word address width; 2^ADDR_W ≥ WORDS.

Ports:
- CLK  in  1  system clock (50 MHz, shared with VGA).
- RESET  in  1  synchronous, active-high.
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave controls.
- AVL_BYTE_EN  in  4  write byte enables.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data.
- DrawX, DrawY  in  10 each  current VGA pixel.
- pix_wall  out  1  wall bit for the pixel presented 2 cycles earlier.
- frame_start  in  1  one-cycle scan request (vs edge, generated by the parent).
- obj_x, obj_y  in  NUM_OBJ*10 each  packed object pixel positions; channel i is bits [10i+9:10i].
- obj_wall_up, obj_wall_down, obj_wall_left, obj_wall_right  out  NUM_OBJ each  committed neighbour-wall flags.
- scan_busy  out  1  high while a scan is running.
- scan_done  out  1  one-cycle pulse when flags commit.

## Operation
- Cell index c = cy*COLS + cx. Word = c>>5. Bit = 31 - (c & 31), i.e. MSB = leftmost cell.
- Write: AVL_CS & AVL_WRITE with AVL_ADDR < WORDS updates only the enabled bytes. The new value is visible to all lookups from the next cycle. Writes with AVL_ADDR ≥ WORDS are dropped.
- Read: AVL_CS & AVL_READ. AVL_READDATA holds the word (0 if AVL_ADDR ≥ WORDS) on the next cycle and keeps it until the next read.
- Pixel path: cx = DrawX>>CELL_SHIFT, cy = DrawY>>CELL_SHIFT.
  - Stage 1 registers the word/bit select.
  - Stage 2 registers the bit.
  - Off-grid (cx ≥ COLS or cy ≥ ROWS) gives 0.
- Scan FSM:
  - States: IDLE → LATCH → PROBE → COMMIT → IDLE.
  - IDLE: frame_start → LATCH.
  - LATCH (1 cycle): snapshot all obj_x/obj_y.
  - PROBE: counter k = 0..4*NUM_OBJ-1; object k>>2, direction k&3 (0 up, 1 down, 2 left, 3 right). One lookup per cycle on a single dedicated port; the result goes to a shadow register.
  - COMMIT (1 cycle): copy shadow to outputs and pulse scan_done.
- Probe neighbour cell: up (cx, cy-1), down (cx, cy+1), left (cx-1, cy), right (cx+1, cy). A neighbour off-grid, or an object whose own cell is off-grid, reads as 1 (wall). Row wrap is never used: cx = 0 → left is a wall.
- frame_start while scan_busy is ignored. There is no queueing.
- Outputs change only at COMMIT, so consumers never see a mixed frame.

## Timing
- Reset (synchronous):
  - Every word in the array = 0.
  - AVL_READDATA = 0, pix_wall = 0.
  - All obj_wall_* = 0, scan_busy = 0, scan_done = 0.
  - FSM = IDLE.
  - RESET mid-scan aborts the scan with no commit.
- AVL read latency is 1 cycle. Writes take effect in 1 cycle. Read and write in the same cycle to the same word returns the old data.
- pix_wall latency is 2 CLK cycles from DrawX/DrawY.
- Scan timing:
  - scan_busy rises the cycle after frame_start and stays high through COMMIT (2 + 4*NUM_OBJ cycles).
  - scan_done is high on the COMMIT cycle only.
  - Defaults: 18 cycles, far below one frame.
- A write landing during PROBE is seen by every probe issued on later cycles.

## Configuration
- MAZE_READBACK_EN:
  - Defined: Avalon read path as described.
  - Undefined: AVL_READDATA is tied to 32'h0 and the read mux is removed. AVL_READ is ignored, and writes and scans are unaffected.

## Test plan
- Reset, then read addr 0 and addr 599 → AVL_READDATA = 0 one cycle after each read; pix_wall = 0 for all pixels.
- Write addr 5 = 32'h8000_0001 with BYTE_EN = 4'b1001 → read returns 32'h8000_0001. Pixel check (defaults, MSB = cx 0):
  - DrawX = 0, DrawY = 4 (cell 160 = word 5 bit 31) → pix_wall = 1 exactly 2 cycles later.
  - DrawX = 124, DrawY = 4 (cell 191 = word 5 bit 0) → pix_wall = 1.
  - DrawX = 4 → 0.
- Write BYTE_EN = 4'b0010 with data 32'hFFFF_FFFF over a zero word → word reads 32'h0000_FF00. Write to addr 700 → no array change.
- Object 0 at (0,0) on an empty maze, frame_start → after 2 + 4*NUM_OBJ cycles: scan_done pulses, obj_wall_up[0] = 1, obj_wall_left[0] = 1, down = 0, right = 0.
- Set the wall bit for cell (11,10), object 1 at pixel (40,40) → obj_wall_right[1] = 1. Pulse frame_start again mid-scan → ignored, exactly one scan_done.
- Assert RESET on PROBE cycle 3 → no scan_done, flags stay 0, scan_busy = 0 next cycle.
